reg_file_port_arbiter: RTL and testbench
========================================

REG_FILE_PORT_ARBITER -- requirements
Module: reg_file_port_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- LEN_REG_FILE_ADDR, 5: register address width.
- SIZE_REG_FILE, 32: number of registers.
- LEN_WORD, 32: data width.
- STARVE_LIMIT, 4: consecutive ll wait cycles before forced grant, range 1..15.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: the only clock; everything is synchronous to its rising edge.
- reset, in, 1: synchronous, active-low reset.
- wb_valid, in, 1: pipeline writeback request.
- wb_dst, in, LEN_REG_FILE_ADDR: writeback destination.
- wb_data, in, LEN_WORD: writeback data.
- ll_valid, in, 1: long-latency unit (mult/div) request.
- ll_dst, in, LEN_REG_FILE_ADDR: long-latency destination.
- ll_data, in, LEN_WORD: long-latency data.
- ll_ready, out, 1: ll request accepted this cycle.
- stall, out, 1: pipeline must hold; wb_valid is ignored while high.
- write_en, out, 1: register-file write enable.
- dst, out, LEN_REG_FILE_ADDR: register-file write address.
- write_data, out, LEN_WORD: register-file write data.
- init_done, out, 1: clear sweep complete.

Function
REQ-003 The FSM SHALL have exactly two states, INIT and RUN; reset SHALL force INIT.
REQ-004 INIT SHALL sweep the address counter from 1 to SIZE_REG_FILE-1, one address per cycle, driving write_en=1, dst=counter and write_data=0.
REQ-005 INIT SHALL drive stall=1 and ll_ready=0; the sweep SHALL take exactly SIZE_REG_FILE-1 cycles.
REQ-006 After the cycle that writes address SIZE_REG_FILE-1, the FSM SHALL enter RUN, and init_done SHALL be registered high from the first RUN cycle on.
REQ-007 RUN grant priority SHALL be:
- (a) forced-ll when the starvation count equals STARVE_LIMIT and ll_valid=1;
- (b) otherwise wb when wb_valid=1;
- (c) otherwise ll when ll_valid=1;
- (d) otherwise idle.
REQ-008 In RUN, stall SHALL equal 1 only in a forced-ll cycle; wb_valid in that cycle SHALL be ignored, and the pipeline re-presents it the next cycle.
REQ-009 A granted request SHALL drive dst and write_data from the winner combinationally, so the register file is written at the same rising edge (zero-cycle latency).
REQ-010 ll_ready SHALL be 1 exactly in cycles where ll wins.
REQ-011 A granted request with destination 0 SHALL produce write_en=0, but the ll handshake SHALL still complete.
REQ-012 The starvation counter (4 bits) SHALL:
- increment each RUN cycle where ll_valid=1 and ll_ready=0;
- saturate at STARVE_LIMIT;
- clear on any ll grant or when ll_valid=0.
REQ-013 When idle or in INIT outside the sweep, dst and write_data SHALL be 0 and write_en SHALL be 0.
REQ-014 ll_dst and ll_data SHALL be held stable by the requester while ll_valid=1 and ll_ready=0; the arbiter SHALL NOT buffer them.
REQ-015 Simultaneous wb and ll requests to the same dst SHALL produce only the winner's write that cycle; the loser writes in a later cycle, and final order follows grant order.

Reset
REQ-016 While reset=0 at a rising edge, the next-state values SHALL be:
- state=INIT, counter=1, starvation count=0, init_done=0;
- outputs write_en=0, ll_ready=0, stall=1.
REQ-017 Reset asserted mid-sweep or mid-RUN SHALL abort the current grant and restart the sweep at address 1 on the first cycle after release.
REQ-018 In a cycle where reset=0 is sampled, write_en SHALL be 0 regardless of state.

Structure
REQ-019 The state encoding (INIT=0, RUN=1) and the STARVE_LIMIT default SHALL live in the shared MemReg package.
REQ-020 The starvation counter SHALL be a separate sub-module, StarveCounter (inputs: inc, clr; output: at_limit).
REQ-021 The block SHALL contain no storage for request data; all state is the FSM, the address counter, init_done and the starvation count.

Verification
REQ-022 Bench scenarios, all with SIZE_REG_FILE=32 and STARVE_LIMIT=4, SHALL cover:
- Reset release: exactly 31 cycles of write_en=1 with dst 1..31 and data 0, then init_done=1 and stall=0 on cycle 32.
- RUN, wb_valid=1, wb_dst=5, wb_data=0xDEADBEEF: write_en=1, dst=5, write_data=0xDEADBEEF in the same cycle, and register 5 reads 0xDEADBEEF next cycle.
- wb_valid held 1 continuously with ll_valid=1, ll_dst=7: ll_ready=0 for 4 cycles, then one cycle with stall=1, ll_ready=1 and dst=7, then the counter returns to 0.
- ll_valid=1 and ll_dst=0 with wb idle: ll_ready=1 and write_en=0.
- Reset=0 asserted at sweep address 10 for 2 cycles: write_en=0 during reset, and the sweep restarts at dst=1 with 31 writes.
- Same-cycle wb and ll to dst=9 (data 0x1 and 0x2): 0x1 is written first and 0x2 the next cycle, so register 9 holds 0x2.

Source files
------------

// File: rtl/MemReg.sv
// Shared definitions for the register-file write-port arbiter.
package MemReg;

  // Two-state arbiter FSM: clear sweep, then normal arbitration.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Consecutive ll wait cycles before the ll port is forced through.
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  // Width of the starvation counter; limits STARVE_LIMIT to 1..15.
  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/StarveCounter.sv
// Counts consecutive cycles the long-latency port has been kept waiting.
module StarveCounter
  import MemReg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/reg_file_port_arbiter.sv
// Single register-file write port shared by pipeline writeback and the
// long-latency unit; clears registers 1..N-1 after reset.
module reg_file_port_arbiter
  import MemReg::*;
#(
  parameter int unsigned LEN_REG_FILE_ADDR = 5,
  parameter int unsigned SIZE_REG_FILE     = 32,
  parameter int unsigned LEN_WORD          = 32,
  parameter int unsigned STARVE_LIMIT      = STARVE_LIMIT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb_valid,
  input  logic [LEN_REG_FILE_ADDR-1:0] wb_dst,
  input  logic [LEN_WORD-1:0]          wb_data,
  input  logic                         ll_valid,
  input  logic [LEN_REG_FILE_ADDR-1:0] ll_dst,
  input  logic [LEN_WORD-1:0]          ll_data,
  output logic                         ll_ready,
  output logic                         stall,
  output logic                         write_en,
  output logic [LEN_REG_FILE_ADDR-1:0] dst,
  output logic [LEN_WORD-1:0]          write_data,
  output logic                         init_done
);

  localparam logic [LEN_REG_FILE_ADDR-1:0] FIRST_ADDR = LEN_REG_FILE_ADDR'(1);
  localparam logic [LEN_REG_FILE_ADDR-1:0] LAST_ADDR  = LEN_REG_FILE_ADDR'(SIZE_REG_FILE - 1);

  state_e                         state_q, state_d;
  logic [LEN_REG_FILE_ADDR-1:0]   addr_q, addr_d;
  logic                           init_done_q, init_done_d;
  logic                           at_limit;
  logic                           grant;
  logic                           starve_inc;
  logic                           starve_clr;

  // ll waits while it asks and is not served; any grant or a dropped request clears it.
  assign starve_inc = (state_q == RUN) && ll_valid && !ll_ready;
  assign starve_clr = !ll_valid || ll_ready;

  StarveCounter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .at_limit(at_limit)
  );

  // Next-state and grant logic; the winner drives the write port in the same cycle.
  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    init_done_d = init_done_q;
    grant       = 1'b0;
    ll_ready    = 1'b0;
    stall       = 1'b1;
    write_en    = 1'b0;
    dst         = '0;
    write_data  = '0;

    case (state_q)
      INIT: begin
        write_en = 1'b1;
        dst      = addr_q;
        if (addr_q == LAST_ADDR) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          addr_d = addr_q + LEN_REG_FILE_ADDR'(1);
        end
      end
      RUN: begin
        stall = 1'b0;
        if (at_limit && ll_valid) begin
          // Forced ll: the pipeline holds and re-presents its writeback.
          grant      = 1'b1;
          stall      = 1'b1;
          ll_ready   = 1'b1;
          dst        = ll_dst;
          write_data = ll_data;
        end else if (wb_valid) begin
          grant      = 1'b1;
          dst        = wb_dst;
          write_data = wb_data;
        end else if (ll_valid) begin
          grant      = 1'b1;
          ll_ready   = 1'b1;
          dst        = ll_dst;
          write_data = ll_data;
        end
        // Register 0 is hardwired; the handshake still completes.
        write_en = grant && (dst != '0);
      end
    endcase

    // A sampled reset aborts whatever would have been granted this cycle.
    if (!reset) begin
      ll_ready   = 1'b0;
      stall      = 1'b1;
      write_en   = 1'b0;
      dst        = '0;
      write_data = '0;
    end
  end

  // FSM, sweep address and init_done registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= INIT;
      addr_q      <= FIRST_ADDR;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_done = init_done_q;

endmodule

// File: tb/tb_reg_file_port_arbiter.sv
// Scoreboard bench for reg_file_port_arbiter (32 registers, STARVE_LIMIT 4).
module tb_reg_file_port_arbiter;

  typedef struct packed {
    logic        rst;
    logic        wbv;
    logic [4:0]  wbd;
    logic [31:0] wbdat;
    logic        llv;
    logic [4:0]  lld;
    logic [31:0] lldat;
  } stim_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  dst;
    logic [31:0] data;
    logic        rdy;
    logic        stall;
    logic        done;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        ll_valid;
  logic [4:0]  ll_dst;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic        stall;
  logic        write_en;
  logic [4:0]  dst;
  logic [31:0] write_data;
  logic        init_done;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  exp_t        exp_q[$];
  logic [31:0] rf [32];

  reg_file_port_arbiter #(
    .LEN_REG_FILE_ADDR(5),
    .SIZE_REG_FILE    (32),
    .LEN_WORD         (32),
    .STARVE_LIMIT     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_dst    (wb_dst),
    .wb_data   (wb_data),
    .ll_valid  (ll_valid),
    .ll_dst    (ll_dst),
    .ll_data   (ll_data),
    .ll_ready  (ll_ready),
    .stall     (stall),
    .write_en  (write_en),
    .dst       (dst),
    .write_data(write_data),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file as the write port would update it.
  always @(posedge clk) begin
    if (write_en) rf[dst] <= write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic stim_t st(input logic rst, input logic wbv, input logic [4:0] wbd,
                               input logic [31:0] wbdat, input logic llv,
                               input logic [4:0] lld, input logic [31:0] lldat);
    return {rst, wbv, wbd, wbdat, llv, lld, lldat};
  endfunction

  function automatic exp_t ex(input logic we, input logic [4:0] d, input logic [31:0] dat,
                              input logic rdy, input logic stl, input logic dn);
    return {we, d, dat, rdy, stl, dn};
  endfunction

  // Drive one cycle at the falling edge, queue its expectation, compare before the rising edge.
  task automatic apply(input string tag, input stim_t s, input exp_t e);
    exp_t want;
    @(negedge clk);
    reset    = s.rst;
    wb_valid = s.wbv;
    wb_dst   = s.wbd;
    wb_data  = s.wbdat;
    ll_valid = s.llv;
    ll_dst   = s.lld;
    ll_data  = s.lldat;
    exp_q.push_back(e);
    #2;
    want = exp_q.pop_front();
    check({tag, ".we"},    32'(write_en),   32'(want.we));
    check({tag, ".dst"},   32'(dst),        32'(want.dst));
    check({tag, ".data"},  write_data,      want.data);
    check({tag, ".rdy"},   32'(ll_ready),   32'(want.rdy));
    check({tag, ".stall"}, 32'(stall),      32'(want.stall));
    check({tag, ".done"},  32'(init_done),  32'(want.done));
  endtask

  task automatic sweep(input string tag, input int n);
    for (int i = 1; i <= n; i++)
      apply($sformatf("%s%0d", tag, i), st(1, 1, 5'd20, 32'h55, 0, 0, 0),
            ex(1, 5'(i), 0, 0, 1, 0));
  endtask

  initial begin
    reset = 1'b0; wb_valid = 1'b0; wb_dst = '0; wb_data = '0;
    ll_valid = 1'b0; ll_dst = '0; ll_data = '0;

    // Reset, then the full clear sweep with a writeback request being ignored.
    for (int i = 0; i < 2; i++)
      apply("rst", st(0, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66), ex(0, 0, 0, 0, 1, 0));
    sweep("sweep", 31);
    apply("run0", st(1, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1));

    // Plain writeback, visible in the register file next cycle.
    apply("wb5", st(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0), ex(1, 5'd5, 32'hDEADBEEF, 0, 0, 1));
    apply("idle1", st(1, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1));
    check("rf5", rf[5], 32'hDEADBEEF);

    // Starvation: four wb wins, then a forced ll grant, then the count restarts from 0.
    for (int i = 0; i < 4; i++)
      apply($sformatf("starve%0d", i), st(1, 1, 5'd12, 32'hA0 + 32'(i), 1, 5'd7, 32'h77),
            ex(1, 5'd12, 32'hA0 + 32'(i), 0, 0, 1));
    apply("force7", st(1, 1, 5'd12, 32'hA4, 1, 5'd7, 32'h77), ex(1, 5'd7, 32'h77, 1, 1, 1));
    for (int i = 0; i < 4; i++)
      apply($sformatf("restart%0d", i), st(1, 1, 5'd12, 32'hA4 + 32'(i), 1, 5'd8, 32'h88),
            ex(1, 5'd12, 32'hA4 + 32'(i), 0, 0, 1));
    apply("force8", st(1, 1, 5'd12, 32'hA8, 1, 5'd8, 32'h88), ex(1, 5'd8, 32'h88, 1, 1, 1));

    // Dropping ll_valid clears a partial count.
    for (int i = 0; i < 3; i++)
      apply($sformatf("part%0d", i), st(1, 1, 5'd13, 32'hB0, 1, 5'd10, 32'h10),
            ex(1, 5'd13, 32'hB0, 0, 0, 1));
    apply("drop", st(1, 1, 5'd13, 32'hB1, 0, 0, 0), ex(1, 5'd13, 32'hB1, 0, 0, 1));
    for (int i = 0; i < 4; i++)
      apply($sformatf("again%0d", i), st(1, 1, 5'd13, 32'hB2, 1, 5'd10, 32'h10),
            ex(1, 5'd13, 32'hB2, 0, 0, 1));
    apply("force10", st(1, 1, 5'd13, 32'hB2, 1, 5'd10, 32'h10), ex(1, 5'd10, 32'h10, 1, 1, 1));

    // ll to register 0 completes its handshake without writing; normal ll grant.
    apply("ll0", st(1, 0, 0, 0, 1, 5'd0, 32'h1234), ex(0, 5'd0, 32'h1234, 1, 0, 1));
    apply("ll14", st(1, 0, 0, 0, 1, 5'd14, 32'hCAFE), ex(1, 5'd14, 32'hCAFE, 1, 0, 1));

    // Same destination from both ports: wb first, ll next, ll value remains.
    apply("same_a", st(1, 1, 5'd9, 32'h1, 1, 5'd9, 32'h2), ex(1, 5'd9, 32'h1, 0, 0, 1));
    apply("same_b", st(1, 0, 0, 0, 1, 5'd9, 32'h2), ex(1, 5'd9, 32'h2, 1, 0, 1));
    check("rf9_first", rf[9], 32'h1);
    apply("idle2", st(1, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1));
    check("rf9_final", rf[9], 32'h2);

    // Reset mid-RUN aborts a pending grant; init_done drops after the first reset edge.
    apply("mrst0", st(0, 1, 5'd3, 32'h33, 1, 5'd3, 32'h34), ex(0, 0, 0, 0, 1, 1));
    apply("mrst1", st(0, 1, 5'd3, 32'h33, 0, 0, 0), ex(0, 0, 0, 0, 1, 0));

    // Reset at sweep address 10, then a full restart from address 1.
    sweep("part_sweep", 10);
    for (int i = 0; i < 2; i++)
      apply($sformatf("srst%0d", i), st(0, 1, 5'd20, 32'h55, 0, 0, 0), ex(0, 0, 0, 0, 1, 0));
    sweep("resweep", 31);
    apply("run1", st(1, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1));
    check("rf5_clr", rf[5], 32'h0);
    check("rf9_clr", rf[9], 32'h0);
    check("rf31_clr", rf[31], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
